// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing an auto-incrementing 8-bit register file plus a host port.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on SDA/SCL.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADR   = 7'h30,
  parameter int         REG_COUNT = 256,
  parameter int         PTR_W     = $clog2(REG_COUNT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             SDA_i,
  input  logic             SCL_i,
  output logic             SDA_t,
  output logic             SCL_t,
  output logic             SDA_o,
  output logic             SCL_o,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             i2c_wr_pulse,
  output logic [PTR_W-1:0] i2c_wr_addr,
  output logic             busy,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_MACK      = 4'd8,
    S_IGNORE    = 4'd9
  } state_e;

  // Synchronisers reset high so an idle bus produces no spurious edges
  logic [1:0] sda_sync_q, scl_sync_q;
  logic       sda_c, scl_c;
  logic       sda_p_q, scl_p_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sda_sync_q <= 2'b11;
      scl_sync_q <= 2'b11;
    end else begin
      sda_sync_q <= {sda_sync_q[0], SDA_i};
      scl_sync_q <= {scl_sync_q[0], SCL_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] sda_h_q, scl_h_q;
  logic       sda_f_q, scl_f_q;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sda_h_q <= 2'b11;
      scl_h_q <= 2'b11;
      sda_f_q <= 1'b1;
      scl_f_q <= 1'b1;
    end else begin
      sda_h_q <= {sda_h_q[0], sda_sync_q[1]};
      scl_h_q <= {scl_h_q[0], scl_sync_q[1]};
      sda_f_q <= maj3(sda_sync_q[1], sda_h_q[0], sda_h_q[1]);
      scl_f_q <= maj3(scl_sync_q[1], scl_h_q[0], scl_h_q[1]);
    end
  end

  assign sda_c = sda_f_q;
  assign scl_c = scl_f_q;
`else
  assign sda_c = sda_sync_q[1];
  assign scl_c = scl_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = ~scl_p_q & scl_c;
  assign scl_fall = scl_p_q & ~scl_c;
  assign start_c  = scl_p_q & scl_c & sda_p_q & ~sda_c;
  assign stop_c   = scl_p_q & scl_c & ~sda_p_q & sda_c;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             acked_q, acked_d;
  logic             sda_t_q, sda_t_d;
  logic             busy_q, busy_d;
  logic             wr_pulse_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       rdata_q;
  logic [7:0]       regs_q [REG_COUNT];
  logic             commit;
  logic [7:0]       rx_byte, rd_byte;
  logic             last_bit;

  assign rx_byte  = {shift_q[6:0], sda_c};
  assign rd_byte  = regs_q[ptr_q];
  assign last_bit = (cnt_q == 3'd7);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      acked_q    <= 1'b0;
      sda_t_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      sda_p_q    <= 1'b1;
      scl_p_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      acked_q    <= acked_d;
      sda_t_q    <= sda_t_d;
      busy_q     <= busy_d;
      wr_pulse_q <= commit;
      if (commit) wr_addr_q <= ptr_q;
      sda_p_q    <= sda_c;
      scl_p_q    <= scl_c;
    end
  end

  // ACK states use sda_t_q to tell the first fall (drive) from the second (release)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    acked_d = acked_q;
    sda_t_d = sda_t_q;
    busy_d  = busy_q;
    commit  = 1'b0;
    if (stop_c) begin
      state_d = S_IDLE;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      sda_t_d = 1'b1;
    end else begin
      unique case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (last_bit) begin
            if (rx_byte[7:1] == I2C_ADR && rx_byte[7:1] != 7'd0) begin
              state_d = S_ADDR_ACK;
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_PTR: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (last_bit) begin
            ptr_d   = rx_byte[PTR_W-1:0];
            state_d = S_PTR_ACK;
          end
        end
        S_WDATA: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (last_bit) begin
            commit  = 1'b1;
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = S_WDATA_ACK;
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (sda_t_q) begin
            sda_t_d = 1'b0;
          end else if (rw_q) begin
            shift_d = rd_byte;
            sda_t_d = rd_byte[7];
            cnt_d   = '0;
            state_d = S_RDATA;
          end else begin
            sda_t_d = 1'b1;
            cnt_d   = '0;
            state_d = S_PTR;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (sda_t_q) begin
            sda_t_d = 1'b0;
          end else begin
            sda_t_d = 1'b1;
            cnt_d   = '0;
            state_d = S_WDATA;
          end
        end
        S_RDATA: if (scl_fall) begin
          if (last_bit) begin
            sda_t_d = 1'b1;
            acked_d = 1'b0;
            state_d = S_MACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            sda_t_d = shift_q[6];
            cnt_d   = cnt_q + 3'd1;
          end
        end
        S_MACK: begin
          if (scl_rise && !acked_q) begin
            if (!sda_c) begin
              acked_d = 1'b1;
              ptr_d   = ptr_q + PTR_W'(1);
            end else begin
              state_d = S_IGNORE;
            end
          end else if (scl_fall && acked_q) begin
            shift_d = rd_byte;
            sda_t_d = rd_byte[7];
            cnt_d   = '0;
            acked_d = 1'b0;
            state_d = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // An I2C commit beats a host write to the same address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (commit && ptr_q == PTR_W'(i)) begin
          regs_q[i] <= rx_byte;
        end else if (host_we && host_addr == PTR_W'(i)) begin
          regs_q[i] <= host_wdata;
        end
      end
      rdata_q <= regs_q[host_addr];
    end
  end

  always_comb begin
    SDA_t        = sda_t_q;
    SCL_t        = 1'b1;
    SDA_o        = 1'b0;
    SCL_o        = 1'b0;
    busy         = busy_q;
    state        = state_q;
    host_rdata   = rdata_q;
    i2c_wr_pulse = wr_pulse_q;
    i2c_wr_addr  = wr_addr_q;
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master on an open-drain bus
// model plus host-port accesses, all expected values written by hand.
module tb_i2c_slave_regfile;

  localparam int Q = 8;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int SYNC_LAT = 4;
`else
  localparam int SYNC_LAT = 2;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_sda = 1'b1;
  logic       m_scl = 1'b1;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       SDA_t, SCL_t, SDA_o, SCL_o;
  logic [7:0] host_rdata;
  logic       i2c_wr_pulse;
  logic [7:0] i2c_wr_addr;
  logic       busy;
  logic [3:0] state;
  logic       sda_bus, scl_bus;

  assign sda_bus = m_sda & (SDA_t | SDA_o);
  assign scl_bus = m_scl & (SCL_t | SCL_o);

  i2c_slave_regfile dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .SDA_i        (sda_bus),
    .SCL_i        (scl_bus),
    .SDA_t        (SDA_t),
    .SCL_t        (SCL_t),
    .SDA_o        (SDA_o),
    .SCL_o        (SCL_o),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .i2c_wr_pulse (i2c_wr_pulse),
    .i2c_wr_addr  (i2c_wr_addr),
    .busy         (busy),
    .state        (state)
  );

  always #5 clock = ~clock;

  int n_tot = 0;
  int n_pass = 0;
  logic [7:0] wr_log[$];

  always @(negedge clock)
    if (i2c_wr_pulse) wr_log.push_back(i2c_wr_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; wq(Q);
    m_scl = 1'b1; wq(2 * Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    b = sda_bus; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(b);
    ack = ~b;
  endtask

  // Last data bit lines host_we up with the cycle the slave commits the byte
  task automatic wr_byte_col(input logic [7:0] d, input logic [7:0] ha,
                             input logic [7:0] hd, output logic ack);
    logic b;
    for (int i = 7; i >= 1; i--) wr_bit(d[i]);
    m_sda = d[0]; wq(Q);
    m_scl = 1'b1; wq(SYNC_LAT);
    host_addr = ha; host_wdata = hd; host_we = 1'b1; wq(1);
    host_we = 1'b0; wq(2 * Q - SYNC_LAT - 1);
    m_scl = 1'b0; wq(Q);
    rd_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(~mack);
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
    host_addr = a; wq(1);
    d = host_rdata;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;

    wq(3);
    chk("rst_sda_t", SDA_t, 1);
    chk("rst_scl_t", SCL_t, 1);
    chk("rst_sda_o", SDA_o, 0);
    chk("rst_scl_o", SCL_o, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", i2c_wr_pulse, 0);
    chk("rst_rdata", host_rdata, 0);
    reset_n = 1'b1; wq(4);

    wr_log.delete();
    i2c_start();
    wr_byte(8'h60, ack); chk("w_addr_ack", ack, 1);
    chk("w_busy", busy, 1);
    wr_byte(8'h05, ack); chk("w_ptr_ack", ack, 1);
    wr_byte(8'hA5, ack); chk("w_d0_ack", ack, 1);
    wr_byte(8'h3C, ack); chk("w_d1_ack", ack, 1);
    i2c_stop();
    chk("w_busy_stop", busy, 0);
    chk("w_state_stop", state, 0);
    chk("w_pulses", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("w_pulse0", wr_log[0], 8'h05);
      chk("w_pulse1", wr_log[1], 8'h06);
    end
    host_rd(8'h05, d); chk("w_reg5", d, 8'hA5);
    host_rd(8'h06, d); chk("w_reg6", d, 8'h3C);

    i2c_start();
    wr_byte(8'h60, ack); chk("r_addr_ack", ack, 1);
    wr_byte(8'h05, ack); chk("r_ptr_ack", ack, 1);
    i2c_start();
    wr_byte(8'h61, ack); chk("r_addr_r_ack", ack, 1);
    rd_byte(1'b1, d); chk("r_byte0", d, 8'hA5);
    rd_byte(1'b0, d); chk("r_byte1", d, 8'h3C);
    chk("r_nack_sda", SDA_t, 1);
    chk("r_nack_state", state, 9);
    i2c_stop();
    chk("r_stop_state", state, 0);

    i2c_start();
    wr_byte(8'h60, ack); chk("wrap_addr_ack", ack, 1);
    wr_byte(8'hFF, ack); chk("wrap_ptr_ack", ack, 1);
    wr_byte(8'h11, ack); chk("wrap_d0_ack", ack, 1);
    wr_byte(8'h22, ack); chk("wrap_d1_ack", ack, 1);
    i2c_stop();
    host_rd(8'hFF, d); chk("wrap_reg255", d, 8'h11);
    host_rd(8'h00, d); chk("wrap_reg0", d, 8'h22);

    i2c_start();
    wr_byte(8'h62, ack); chk("mis_addr_nack", ack, 0);
    chk("mis_state", state, 9);
    wr_byte(8'h05, ack); chk("mis_ptr_nack", ack, 0);
    chk("mis_state2", state, 9);
    i2c_stop();
    chk("mis_stop_state", state, 0);
    host_rd(8'h05, d); chk("mis_reg5", d, 8'hA5);

    wr_log.delete();
    i2c_start();
    wr_byte(8'h60, ack); chk("col_addr_ack", ack, 1);
    wr_byte(8'h05, ack); chk("col_ptr_ack", ack, 1);
    wr_byte_col(8'h99, 8'h05, 8'h77, ack); chk("col_d_ack", ack, 1);
    i2c_stop();
    chk("col_pulses", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("col_pulse_addr", wr_log[0], 8'h05);
    host_rd(8'h05, d); chk("col_reg5", d, 8'h99);
    host_addr = 8'h0A; host_wdata = 8'h5A; host_we = 1'b1; wq(1);
    host_we = 1'b0;
    host_rd(8'h0A, d); chk("host_wr_reg10", d, 8'h5A);

    i2c_start();
    wr_byte(8'h60, ack); chk("rr_addr_ack", ack, 1);
    wr_byte(8'h06, ack); chk("rr_ptr_ack", ack, 1);
    i2c_start();
    wr_byte(8'h61, ack); chk("rr_addr_r_ack", ack, 1);
    chk("rr_driving", SDA_t, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_sda_rel", SDA_t, 1);
    chk("rr_state", state, 0);
    m_sda = 1'b1; m_scl = 1'b1; wq(2);
    reset_n = 1'b1; wq(4);
    i2c_start();
    wr_byte(8'h61, ack); chk("rr2_addr_ack", ack, 1);
    rd_byte(1'b0, d); chk("rr2_byte", d, 8'h00);
    i2c_stop();
    host_rd(8'h06, d); chk("rr2_reg6", d, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
